spart_tx_bridge: RTL and testbench
==================================

# spart_tx_bridge

Downstream consumer of the in-order CPU's SPART write port. Decodes `spart_wrt_en`/`spart_wrt_add`/`spart_wrt_data` stores into a small byte FIFO and serializes queued bytes onto an 8N1 UART transmit line.

The CPU has no stall input, so the block never back-pressures. Stores that do not fit are dropped and flagged in a sticky overflow bit.

## Interface
Parameters:
- `DEPTH`, 16: byte FIFO entries; must be a power of 2 and ≥ 4.
- `BAUD_DIV`, 434: clock cycles per serial bit; must be ≥ 2.
- `ADDR_TXB`, 32'h0000_C000: byte store; queues `data[7:0]`.
- `ADDR_TXW`, 32'h0000_C004: word store; queues 4 bytes, LSB first.
- `ADDR_CTRL`, 32'h0000_C008: control store; `data[0]`=1 clears `overflow`.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `spart_wrt_en`, input, 1: store strobe from the CPU.
- `spart_wrt_add`, input, 32: store address.
- `spart_wrt_data`, input, 32: store data.
- `txd`, output, 1: serial transmit line; idles high.
- `tx_busy`, output, 1: high when the serializer is not IDLE or the FIFO is non-empty.
- `fifo_count`, output, log2(DEPTH)+1: number of bytes queued.
- `overflow`, output, 1: sticky flag; set when a store is dropped.

## Operation
- Reset (rst=0, asynchronous): `txd`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0. FIFO pointers are 0 and the state is IDLE. Reset asserted mid-frame aborts the frame immediately and sets `txd`=1.
- Address decode is an exact 32-bit match. A store to any other address is ignored and leaves every state unchanged.
- `ADDR_TXB` store: accepted if `fifo_count` ≤ DEPTH-1; otherwise dropped and `overflow` is set.
- `ADDR_TXW` store: all-or-nothing. Accepted if `fifo_count` ≤ DEPTH-4, writing bytes [7:0], [15:8], [23:16], [31:24] in FIFO order. Otherwise no byte is queued and `overflow` is set.
- Space checks use the `fifo_count` registered before the edge. A pop in the same cycle does not create room.
- `ADDR_CTRL` store with `data[0]`=1 clears `overflow`. If a drop happens in the same cycle, it cannot occur, since the control store is the only store that cycle; set therefore never coincides with clear.
- The FIFO is circular and the pointers wrap modulo DEPTH. `fifo_count` is the registered value; a simultaneous push and pop yields count + pushed − 1.
- Serializer FSM, 8N1, LSB first:
  - IDLE: `txd`=1. On an edge with `fifo_count` > 0, pop the head byte into the shift register, drive `txd`=0 and go to START.
  - START: after BAUD_DIV cycles go to DATA with bit index 0 and drive `txd`=shift[0].
  - DATA: each bit is held for BAUD_DIV cycles. After bit 7 go to STOP with `txd`=1.
  - STOP: after BAUD_DIV cycles, if `fifo_count` > 0, pop and enter START directly (no idle gap). Otherwise go to IDLE.
- The baud counter reloads to BAUD_DIV-1 on every bit entry and decrements to 0. The bit boundary is the edge at which the counter equals 0.

## Timing
- `txd` is driven from a register, so there is no combinational path from the inputs to `txd`.
- Latency: a byte store at edge N into an empty FIFO with the FSM in IDLE gives `txd`=0 from edge N+1.
- Each bit lasts exactly BAUD_DIV cycles. One frame is 10·BAUD_DIV cycles, or 11·BAUD_DIV with parity enabled.
- `fifo_count` and `overflow` update at the edge that accepts or drops the store.
- `tx_busy` is 1 from the edge after a store is accepted until the edge where the FSM returns to IDLE with the FIFO empty.

## Configuration
- `SPART_TX_PARITY_EN` defined: adds a PARITY state between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for BAUD_DIV cycles, making the frame 8E1 at 11·BAUD_DIV cycles.
- `SPART_TX_PARITY_EN` undefined: no PARITY state; the frame is 8N1 at 10·BAUD_DIV cycles.
- FIFO and decode behaviour are identical in both builds.

## Test plan
All scenarios use BAUD_DIV=4 and DEPTH=8.
- Reset with `rst`=0 mid-frame: `txd`=1, `fifo_count`=0, `overflow`=0 asynchronously; with no stores after release, `txd` stays 1.
- Byte store of 0x55 to `ADDR_TXB`: `txd`=0 one cycle later; over 40 cycles `txd` carries 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; then `tx_busy`=0.
- Word store of 0x44332211 to `ADDR_TXW`: `fifo_count`=4. Frames 0x11, 0x22, 0x33, 0x44 are sent back-to-back with no idle cycle, 160 cycles total.
- Word store with `fifo_count`=5: dropped, `overflow`=1, `fifo_count` unchanged. A store to `ADDR_CTRL` with data=1 then returns `overflow` to 0.
- Nine byte stores on consecutive cycles while IDLE with the FIFO empty: `fifo_count` goes 1, 1, 2, 3…; when `fifo_count`=DEPTH, the next store sets `overflow` and is not queued. All accepted bytes are transmitted in order.
- Store to 32'h0000_C00C: no state change. With `SPART_TX_PARITY_EN` defined, a byte of 0x07 transmits parity bit 1 and the frame is 44 cycles.

Source files
------------

// File: rtl/spart_tx_bridge_if.sv
// CPU SPART store bus: one-cycle store strobe with address and data.
// No handshake; the consumer must take or drop every strobe in the cycle it arrives.
interface spart_tx_bridge_if;
    logic        spart_wrt_en;
    logic [31:0] spart_wrt_add;
    logic [31:0] spart_wrt_data;

    modport master (output spart_wrt_en, output spart_wrt_add, output spart_wrt_data);
    modport slave  (input  spart_wrt_en, input  spart_wrt_add, input  spart_wrt_data);
endinterface

// File: rtl/spart_tx_bridge.sv
// SPART store decoder feeding a byte FIFO and an 8N1 UART serializer (8E1 with SPART_TX_PARITY_EN).
// Latency: byte stored at edge N into an empty idle bridge drives the start bit from edge N+1.
// Backpressure: never stalls the CPU; stores that do not fit are dropped and flag sticky overflow.
module spart_tx_bridge #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BAUD_DIV  = 434,
    parameter logic [31:0] ADDR_TXB  = 32'h0000_C000,
    parameter logic [31:0] ADDR_TXW  = 32'h0000_C004,
    parameter logic [31:0] ADDR_CTRL = 32'h0000_C008
) (
    input  logic                     clk,
    input  logic                     rst,
    spart_tx_bridge_if.slave         bus,
    output logic                     txd,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LIM_B  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM_W  = CW'(DEPTH - 4);
    localparam logic [BW-1:0] RELOAD = BW'(BAUD_DIV - 1);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          hit_b, hit_w, hit_ctrl, acc_b, acc_w, drop, bit_end, pop;
    logic [CW-1:0] push_n;

    // Space checks use the registered count only, so a same-cycle pop never makes room.
    always_comb begin
        hit_b    = bus.spart_wrt_en && (bus.spart_wrt_add == ADDR_TXB);
        hit_w    = bus.spart_wrt_en && (bus.spart_wrt_add == ADDR_TXW);
        hit_ctrl = bus.spart_wrt_en && (bus.spart_wrt_add == ADDR_CTRL);
        acc_b    = hit_b && (count <= LIM_B);
        acc_w    = hit_w && (count <= LIM_W);
        drop     = (hit_b && !acc_b) || (hit_w && !acc_w);
        push_n   = acc_w ? CW'(4) : (acc_b ? CW'(1) : '0);
        bit_end  = (baud_cnt == '0);
        pop      = (count != '0) && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    end

    always_ff @(posedge clk) begin
        if (acc_b) begin
            mem[wr_ptr] <= bus.spart_wrt_data[7:0];
        end
        if (acc_w) begin
            for (int k = 0; k < 4; k++) begin
                mem[wr_ptr + AW'(k)] <= bus.spart_wrt_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + push_n - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end else if (hit_ctrl && bus.spart_wrt_data[0]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt - BW'(1);
            end
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        txd      <= 1'b0;
                        baud_cnt <= RELOAD;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx  <= '0;
                        txd      <= shift[0];
                        baud_cnt <= RELOAD;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                            txd   <= ^shift;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef SPART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        txd      <= 1'b1;
                        baud_cnt <= RELOAD;
                        state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        // Back-to-back frames: go straight to the next start bit.
                        if (pop) begin
                            shift    <= mem[rd_ptr];
                            txd      <= 1'b0;
                            baud_cnt <= RELOAD;
                            state    <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_count = count;
    assign tx_busy    = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_spart_tx_bridge.sv
// Bench for spart_tx_bridge: constant vector table, directed corner sequences, randomized stores vs a queue model.
module tb_spart_tx_bridge;
    localparam int DEPTH = 8;
    localparam int BAUD  = 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;
    localparam logic [31:0] A_TXB  = 32'h0000_C000;
    localparam logic [31:0] A_TXW  = 32'h0000_C004;
    localparam logic [31:0] A_CTRL = 32'h0000_C008;
    localparam logic [31:0] A_BAD  = 32'h0000_C00C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       txd, tx_busy, overflow;
    logic [3:0] fifo_count;

    spart_tx_bridge_if bus ();

    spart_tx_bridge #(.DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of waiting bytes plus position inside the frame on the wire.
    logic [7:0] mq [$];
    logic [7:0] m_cur = 8'h00;
    int         m_pos = -1;
    logic       m_ovf = 1'b0;

    typedef struct {
        logic        en;
        logic [31:0] a;
        logic [31:0] d;
        int          cnt;
        logic        ovf;
        logic        busy;
        logic        txd;
    } vec_t;
    vec_t tv [16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef SPART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_txd();
        if (m_pos < 0) return 1'b1;
        return frame_bit(m_cur, m_pos / BAUD);
    endfunction

    task automatic model_edge(input logic en, input logic [31:0] a, input logic [31:0] d);
        int old;
        logic do_pop;
        old = mq.size();
        do_pop = 1'b0;
        if (m_pos < 0) begin
            if (old > 0) do_pop = 1'b1;
        end else if (m_pos == FRAME - 1) begin
            if (old > 0) do_pop = 1'b1;
            else m_pos = -1;
        end else begin
            m_pos++;
        end
        if (do_pop) begin
            m_cur = mq.pop_front();
            m_pos = 0;
        end
        if (en) begin
            if (a == A_TXB) begin
                if (old <= DEPTH - 1) mq.push_back(d[7:0]);
                else m_ovf = 1'b1;
            end else if (a == A_TXW) begin
                if (old <= DEPTH - 4) begin
                    for (int k = 0; k < 4; k++) mq.push_back(d[8*k +: 8]);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (a == A_CTRL && d[0]) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        chk("txd", txd, exp_txd());
        chk("fifo_count", fifo_count, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("tx_busy", tx_busy, (m_pos >= 0 || mq.size() > 0) ? 1 : 0);
    endtask

    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d);
        bus.spart_wrt_en   = en;
        bus.spart_wrt_add  = a;
        bus.spart_wrt_data = d;
        @(posedge clk);
        model_edge(en, a, d);
        @(negedge clk);
        bus.spart_wrt_en = 1'b0;
        check_model();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((tx_busy || m_pos >= 0) && n < 3000) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("drain_done", tx_busy, 0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", tx_busy, 0);
        mq.delete();
        m_pos = -1;
        m_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int expc [9];
        logic samp;
        logic [31:0] r, a;

        bus.spart_wrt_en   = 1'b0;
        bus.spart_wrt_add  = '0;
        bus.spart_wrt_data = '0;
        @(negedge clk);
        do_reset();

        tv[0]  = '{1'b1, A_BAD,  32'h0000_00FF, 0, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, A_TXB,  32'h0000_0012, 0, 1'b0, 1'b0, 1'b1};
        tv[2]  = '{1'b1, A_TXW,  32'h4433_2211, 4, 1'b0, 1'b1, 1'b1};
        tv[3]  = '{1'b1, A_TXB,  32'h0000_00AA, 4, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b1, A_TXB,  32'h0000_005A, 5, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, A_TXW,  32'h0102_0304, 5, 1'b1, 1'b1, 1'b0};
        tv[6]  = '{1'b1, A_CTRL, 32'h0000_0000, 5, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{1'b1, A_CTRL, 32'h0000_0001, 5, 1'b0, 1'b1, 1'b1};
        tv[8]  = '{1'b1, A_TXW,  32'h0000_0000, 5, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b1, A_CTRL, 32'hFFFF_FFFF, 5, 1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b1, A_TXB,  32'h0000_0001, 6, 1'b0, 1'b1, 1'b1};
        tv[11] = '{1'b1, A_TXB,  32'h0000_0002, 7, 1'b0, 1'b1, 1'b0};
        tv[12] = '{1'b1, A_TXB,  32'h0000_0003, 8, 1'b0, 1'b1, 1'b0};
        tv[13] = '{1'b1, A_TXB,  32'h0000_0004, 8, 1'b1, 1'b1, 1'b0};
        tv[14] = '{1'b1, A_BAD,  32'h0000_0001, 8, 1'b1, 1'b1, 1'b0};
        tv[15] = '{1'b1, A_CTRL, 32'h0000_0001, 8, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            bus.spart_wrt_en   = tv[i].en;
            bus.spart_wrt_add  = tv[i].a;
            bus.spart_wrt_data = tv[i].d;
            @(posedge clk);
            @(negedge clk);
            bus.spart_wrt_en = 1'b0;
            chk($sformatf("vec%0d_count", i), fifo_count, tv[i].cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, tv[i].ovf);
            chk($sformatf("vec%0d_busy", i), tx_busy, tv[i].busy);
            chk($sformatf("vec%0d_txd", i), txd, tv[i].txd);
        end
        do_reset();

        // Single byte 0x55: start bit one edge after the store, idle after one full frame.
        step(1'b1, A_TXB, 32'h55);
        chk("b55_pre_start", txd, 1);
        step(1'b0, 32'h0, 32'h0);
        chk("b55_start", txd, 0);
        for (int i = 0; i < FRAME; i++) step(1'b0, 32'h0, 32'h0);
        chk("b55_busy_end", tx_busy, 0);

        // Word store: four frames back-to-back.
        step(1'b1, A_TXW, 32'h4433_2211);
        chk("txw_count", fifo_count, 4);
        n = 0;
        while (tx_busy && n < 1000) begin
            step(1'b0, 32'h0, 32'h0);
            if (tx_busy) n++;
        end
        chk("txw_span", n, 4 * FRAME);

        // Word store dropped at count 5, then cleared by the control store.
        step(1'b1, A_TXW, 32'hA1A2_A3A4);
        step(1'b1, A_TXB, 32'hB1);
        step(1'b1, A_TXB, 32'hB2);
        chk("cnt5", fifo_count, 5);
        step(1'b1, A_TXW, 32'hDEAD_BEEF);
        chk("txw_drop_ovf", overflow, 1);
        chk("txw_drop_cnt", fifo_count, 5);
        step(1'b1, A_CTRL, 32'h1);
        chk("ctrl_clear", overflow, 0);
        drain();

        // Burst of byte stores from idle until the FIFO is full, then one more.
        expc = '{1, 1, 2, 3, 4, 5, 6, 7, 8};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, A_TXB, 32'h30 + i);
            chk($sformatf("burst%0d_count", i), fifo_count, expc[i]);
            chk($sformatf("burst%0d_ovf", i), overflow, 0);
        end
        step(1'b1, A_TXB, 32'h3F);
        chk("burst_full_ovf", overflow, 1);
        chk("burst_full_cnt", fifo_count, 8);
        drain();
        step(1'b1, A_CTRL, 32'h1);

        // Unmapped address is ignored.
        step(1'b1, A_BAD, 32'h1);
        chk("bad_count", fifo_count, 0);
        chk("bad_busy", tx_busy, 0);

        // Byte 0x07: bit 9 is the even-parity bit (1) or the stop bit (1); frame length fixed.
        step(1'b1, A_TXB, 32'h07);
        n = 0;
        samp = 1'b0;
        while (tx_busy && n < 1000) begin
            step(1'b0, 32'h0, 32'h0);
            if (n == 37) samp = txd;
            if (tx_busy) n++;
        end
        chk("b07_bit9", samp, 1);
`ifdef SPART_TX_PARITY_EN
        chk("b07_frame_len", n, 44);
`else
        chk("b07_frame_len", n, 40);
`endif

        // Reset in the middle of a frame.
        step(1'b1, A_TXW, 32'h0F0F_0F0F);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 32'h0);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 32'h0);
        chk("post_rst_txd", txd, 1);

        // Randomized stores against the model.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      step(1'b0, $urandom, $urandom);
            else if (r < 72) step(1'b1, A_TXB, $urandom);
            else if (r < 82) step(1'b1, A_TXW, $urandom);
            else if (r < 88) step(1'b1, A_CTRL, $urandom);
            else if (r < 94) step(1'b1, A_BAD, $urandom);
            else begin
                a = 32'h0000_C000 | 32'($urandom_range(0, 15));
                step(1'b1, a, $urandom);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
